// File: rtl/barret_reduce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : barret_reduce_pipe                                           |
// | Description : 3-stage pipelined Barrett reducer, r = a mod Q, with         |
// |               valid/ready streaming handshake and a sideband tag.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module barret_reduce_pipe #(
    parameter int unsigned Q  = 2447,
    parameter int unsigned QW = 12,
    parameter int unsigned IW = 2*QW-1,
    parameter int unsigned TW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [IW-1:0] din_a,
    input  logic [TW-1:0] din_tag,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [QW-1:0] dout_r,
    output logic [TW-1:0] dout_tag
);

    localparam int unsigned c_K   = 2*QW;
    localparam int unsigned c_MW  = c_K - QW + 1;
    localparam int unsigned c_PW  = IW + c_MW;
    localparam int unsigned c_QTW = c_PW - c_K;
    localparam int unsigned c_RW  = QW + 2;

    localparam logic [c_K:0]      c_POW = {1'b1, {c_K{1'b0}}};
    localparam logic [c_K:0]      c_QX  = (c_K+1)'(Q);
    localparam logic [c_MW-1:0]   c_M   = c_MW'(c_POW / c_QX);
    localparam logic [IW-1:0]     c_QI  = IW'(Q);
    localparam logic [c_RW-1:0]   c_QR  = c_RW'(Q);

    logic             r_s1_valid;
    logic [c_PW-1:0]  r_s1_p;
    logic [IW-1:0]    r_s1_a;
    logic [TW-1:0]    r_s1_tag;

    logic             r_s2_valid;
    logic [c_RW-1:0]  r_s2_r0;
    logic [TW-1:0]    r_s2_tag;

    logic             r_out_valid;
    logic [QW-1:0]    r_out_r;
    logic [TW-1:0]    r_out_tag;

    logic             w_stall;
    logic [c_PW-1:0]  w_p;
    logic [c_QTW-1:0] w_q;
    logic [IW-1:0]    w_qq;
    logic [c_RW-1:0]  w_r0;
    logic [c_RW-1:0]  w_r1;
    logic [c_RW-1:0]  w_r2;

    // A full output register with no taker freezes the whole pipe.
    assign w_stall   = r_out_valid & ~dout_ready;
    assign din_ready = ~w_stall | ~rst_n;

    assign w_p  = c_PW'(din_a) * c_PW'(c_M);
    assign w_q  = c_QTW'(r_s1_p >> c_K);
    assign w_qq = IW'(w_q) * c_QI;
    // The quotient estimate undershoots by at most 2, so r0 < 3Q fits c_RW bits.
    assign w_r0 = c_RW'(r_s1_a - w_qq);

    assign w_r1 = (r_s2_r0 >= c_QR) ? (r_s2_r0 - c_QR) : r_s2_r0;
    assign w_r2 = (w_r1 >= c_QR) ? (w_r1 - c_QR) : w_r1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_p      <= '0;
            r_s1_a      <= '0;
            r_s1_tag    <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_r0     <= '0;
            r_s2_tag    <= '0;
            r_out_valid <= 1'b0;
            r_out_r     <= '0;
            r_out_tag   <= '0;
        end else if (!w_stall) begin
            r_s1_valid  <= din_valid;
            r_s1_p      <= w_p;
            r_s1_a      <= din_a;
            r_s1_tag    <= din_tag;
            r_s2_valid  <= r_s1_valid;
            r_s2_r0     <= w_r0;
            r_s2_tag    <= r_s1_tag;
            r_out_valid <= r_s2_valid;
            r_out_r     <= QW'(w_r2);
            r_out_tag   <= r_s2_tag;
        end
    end

    assign dout_valid = r_out_valid;
    assign dout_r     = r_out_r;
    assign dout_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_barret_reduce_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_barret_reduce_pipe                                        |
// | Description : Directed self-checking bench for barret_reduce_pipe.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_barret_reduce_pipe;

    localparam int c_RAND_N = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [22:0] din_a = '0;
    logic [3:0]  din_tag = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [11:0] dout_r;
    logic [3:0]  dout_tag;

    logic        k_din_valid = 1'b0;
    logic        k_din_ready;
    logic [22:0] k_din_a = '0;
    logic [3:0]  k_din_tag = '0;
    logic        k_dout_valid;
    logic        k_dout_ready = 1'b1;
    logic [11:0] k_dout_r;
    logic [3:0]  k_dout_tag;

    int checks = 0;
    int failures = 0;

    barret_reduce_pipe u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din_a      (din_a),
        .din_tag    (din_tag),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_r     (dout_r),
        .dout_tag   (dout_tag)
    );

    barret_reduce_pipe #(.Q(3329), .QW(12), .IW(23), .TW(4)) u_dut_k (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (k_din_valid),
        .din_ready  (k_din_ready),
        .din_a      (k_din_a),
        .din_tag    (k_din_tag),
        .dout_valid (k_dout_valid),
        .dout_ready (k_dout_ready),
        .dout_r     (k_dout_r),
        .dout_tag   (k_dout_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic test_reset();
        rst_n = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (din_ready !== 1'b1) begin failures++; $display("FAIL reset_din_ready: got %b expected 1", din_ready); end
        checks++;
        if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid: got %b expected 0", dout_valid); end
        checks++;
        if (dout_r !== 12'd0 || dout_tag !== 4'd0) begin
            failures++; $display("FAIL reset_dout_data: got r=%0d tag=%0d expected r=0 tag=0", dout_r, dout_tag);
        end
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (dout_valid !== 1'b0) begin failures++; $display("FAIL idle_dout_valid: got %b expected 0", dout_valid); end
    endtask

    task automatic test_sweep();
        logic [15:0] exp_q[$];
        logic [15:0] e;
        int sent = 0, got = 0, cyc = 0, first = -1;
        while (got < 2447 && cyc < 2600) begin
            @(negedge clk);
            din_valid = (sent < 2447);
            din_a = 23'(sent);
            din_tag = 4'(sent);
            dout_ready = 1'b1;
            #1;
            if (dout_valid && dout_ready) begin
                if (first < 0) first = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL sweep_spurious: got r=%0d expected no output", dout_r);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_tag, dout_r} !== e) begin
                        failures++;
                        $display("FAIL sweep_data: got tag=%0d r=%0d expected tag=%0d r=%0d", dout_tag, dout_r, e[15:12], e[11:0]);
                    end
                end
                got++;
            end
            if (din_valid && din_ready) begin
                exp_q.push_back({4'(sent), 12'(sent)});
                sent++;
            end
            cyc++;
        end
        din_valid = 1'b0;
        checks++;
        if (first != 3) begin failures++; $display("FAIL sweep_latency: got %0d expected 3", first); end
        checks++;
        if (cyc != 2450) begin failures++; $display("FAIL sweep_throughput: got %0d cycles expected 2450", cyc); end
    endtask

    task automatic test_boundaries();
        logic [22:0] a_tbl[6] = '{23'd2447, 23'd4893, 23'd5987808, 23'd8388607, 23'd0, 23'd2446};
        logic [11:0] r_tbl[6] = '{12'd0, 12'd2446, 12'd2446, 12'd291, 12'd0, 12'd2446};
        int sent = 0, got = 0, cyc = 0;
        while (got < 6 && cyc < 30) begin
            @(negedge clk);
            din_valid = (sent < 6);
            din_a = (sent < 6) ? a_tbl[sent] : 23'd0;
            din_tag = 4'(sent + 8);
            dout_ready = 1'b1;
            #1;
            if (dout_valid && dout_ready) begin
                checks++;
                if (got >= sent) begin
                    failures++; $display("FAIL bound_spurious: got r=%0d expected no output", dout_r);
                end else if (dout_r !== r_tbl[got] || dout_tag !== 4'(got + 8)) begin
                    failures++;
                    $display("FAIL bound_data[%0d]: got tag=%0d r=%0d expected tag=%0d r=%0d", got, dout_tag, dout_r, got + 8, r_tbl[got]);
                end
                got++;
            end
            if (din_valid && din_ready) sent++;
            cyc++;
        end
        din_valid = 1'b0;
        checks++;
        if (got != 6) begin failures++; $display("FAIL bound_count: got %0d expected 6", got); end
    endtask

    task automatic test_stall();
        logic [22:0] a_tbl[4] = '{23'd100, 23'd2500, 23'd7000000, 23'd4894};
        logic [11:0] r_tbl[4] = '{12'd100, 12'd53, 12'd1580, 12'd0};
        logic [11:0] prev_r = '0;
        logic [3:0]  prev_tag = '0;
        bit prev_stall = 1'b0;
        int sent = 0, got = 0, cyc = 0;
        while (got < 4 && cyc < 40) begin
            @(negedge clk);
            din_valid = (sent < 4);
            din_a = (sent < 4) ? a_tbl[sent] : 23'd0;
            din_tag = 4'(sent + 1);
            dout_ready = !(cyc >= 3 && cyc < 8);
            #1;
            if (cyc >= 3 && cyc < 8) begin
                checks++;
                if (din_ready !== 1'b0 || dout_valid !== 1'b1) begin
                    failures++; $display("FAIL stall_ready: got din_ready=%b dout_valid=%b expected 0 1", din_ready, dout_valid);
                end
            end
            if (prev_stall) begin
                checks++;
                if (dout_r !== prev_r || dout_tag !== prev_tag) begin
                    failures++; $display("FAIL stall_hold: got r=%0d tag=%0d expected r=%0d tag=%0d", dout_r, dout_tag, prev_r, prev_tag);
                end
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (got >= sent) begin
                    failures++; $display("FAIL stall_spurious: got r=%0d expected no output", dout_r);
                end else if (dout_r !== r_tbl[got] || dout_tag !== 4'(got + 1)) begin
                    failures++;
                    $display("FAIL stall_data[%0d]: got tag=%0d r=%0d expected tag=%0d r=%0d", got, dout_tag, dout_r, got + 1, r_tbl[got]);
                end
                got++;
            end
            if (din_valid && din_ready) sent++;
            prev_stall = dout_valid && !dout_ready;
            prev_r = dout_r;
            prev_tag = dout_tag;
            cyc++;
        end
        din_valid = 1'b0;
        checks++;
        if (got != 4 || cyc != 12) begin failures++; $display("FAIL stall_drain: got %0d results by cycle %0d expected 4 by cycle 12", got, cyc); end
    endtask

    task automatic test_random();
        logic [15:0] exp_q[$];
        logic [15:0] e;
        logic [11:0] prev_r = '0;
        logic [3:0]  prev_tag = '0;
        bit prev_stall = 1'b0, hold = 1'b0;
        int sent = 0, got = 0, cyc = 0;
        while (got < c_RAND_N && cyc < c_RAND_N * 8) begin
            @(negedge clk);
            if (!hold) begin
                din_valid = (sent < c_RAND_N) && ($urandom_range(0, 3) != 0);
                din_a = 23'($urandom);
                din_tag = 4'($urandom);
            end
            dout_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (prev_stall) begin
                checks++;
                if (dout_valid !== 1'b1 || dout_r !== prev_r || dout_tag !== prev_tag) begin
                    failures++; $display("FAIL rand_hold: got r=%0d tag=%0d expected r=%0d tag=%0d", dout_r, dout_tag, prev_r, prev_tag);
                end
            end
            if (dout_valid && dout_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious: got r=%0d expected no output", dout_r);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_tag, dout_r} !== e) begin
                        failures++;
                        $display("FAIL rand_data: got tag=%0d r=%0d expected tag=%0d r=%0d", dout_tag, dout_r, e[15:12], e[11:0]);
                    end
                end
                got++;
            end
            if (din_valid && din_ready) begin
                exp_q.push_back({din_tag, 12'(din_a % 23'd2447)});
                sent++;
                hold = 1'b0;
            end else begin
                hold = din_valid;
            end
            prev_stall = dout_valid && !dout_ready;
            prev_r = dout_r;
            prev_tag = dout_tag;
            cyc++;
        end
        din_valid = 1'b0;
        checks++;
        if (got != c_RAND_N || exp_q.size() != 0) begin
            failures++; $display("FAIL rand_count: got %0d results expected %0d", got, c_RAND_N);
        end
    endtask

    task automatic test_reset_inflight();
        int seen = -1, extra = 0;
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            din_valid = 1'b1; din_a = 23'(3000 + i); din_tag = 4'(i + 1);
        end
        @(negedge clk);
        din_valid = 1'b0; rst_n = 1'b0;
        #1;
        checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b1) begin
            failures++; $display("FAIL rst_inflight_pre: got din_ready=%b dout_valid=%b expected 1 1", din_ready, dout_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || dout_r !== 12'd0 || dout_tag !== 4'd0) begin
            failures++; $display("FAIL rst_inflight_clear: got valid=%b r=%0d tag=%0d expected 0 0 0", dout_valid, dout_r, dout_tag);
        end
        din_valid = 1'b1; din_a = 23'd5000; din_tag = 4'd9; dout_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            din_valid = 1'b0;
            #1;
            if (dout_valid) begin
                if (seen < 0) begin
                    seen = i;
                    checks++;
                    if (dout_r !== 12'd106 || dout_tag !== 4'd9) begin
                        failures++; $display("FAIL rst_new_data: got r=%0d tag=%0d expected r=106 tag=9", dout_r, dout_tag);
                    end
                end else begin
                    extra++;
                end
            end
        end
        checks++;
        if (seen != 3) begin failures++; $display("FAIL rst_new_latency: got %0d expected 3", seen); end
        checks++;
        if (extra != 0) begin failures++; $display("FAIL rst_stale: got %0d extra results expected 0", extra); end
    endtask

    task automatic test_param_override();
        logic [22:0] a_tbl[4] = '{23'd8388607, 23'd3329, 23'd3328, 23'd6657};
        logic [11:0] r_tbl[4] = '{12'd2856, 12'd0, 12'd3328, 12'd3328};
        int sent = 0, got = 0, cyc = 0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            k_din_valid = (sent < 4);
            k_din_a = (sent < 4) ? a_tbl[sent] : 23'd0;
            k_din_tag = 4'(sent + 4);
            k_dout_ready = 1'b1;
            #1;
            if (k_dout_valid && k_dout_ready) begin
                checks++;
                if (got >= sent) begin
                    failures++; $display("FAIL q3329_spurious: got r=%0d expected no output", k_dout_r);
                end else if (k_dout_r !== r_tbl[got] || k_dout_tag !== 4'(got + 4)) begin
                    failures++;
                    $display("FAIL q3329_data[%0d]: got tag=%0d r=%0d expected tag=%0d r=%0d", got, k_dout_tag, k_dout_r, got + 4, r_tbl[got]);
                end
                got++;
            end
            if (k_din_valid && k_din_ready) sent++;
            cyc++;
        end
        k_din_valid = 1'b0;
        checks++;
        if (got != 4) begin failures++; $display("FAIL q3329_count: got %0d expected 4", got); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_boundaries();
        test_stall();
        test_random();
        test_reset_inflight();
        test_param_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
